// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - segment encodings and nibble decode function
package seven_segment_pkg;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = hex_mode ? SEG_A : SEG_BLANK;
            4'hB:    pattern = hex_mode ? SEG_B : SEG_BLANK;
            4'hC:    pattern = hex_mode ? SEG_C : SEG_BLANK;
            4'hD:    pattern = hex_mode ? SEG_D : SEG_BLANK;
            4'hE:    pattern = hex_mode ? SEG_E : SEG_BLANK;
            default: pattern = hex_mode ? SEG_F : SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_segment_hex.sv
// rtl/seven_segment_hex.sv - combinational nibble to segment decoder
module seven_segment_hex
    import seven_segment_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg_encode(nibble, HEX_MODE != 0);

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed N-digit seven-segment scan driver
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int HEX_MODE     = 1,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int              PW       = $clog2(REFRESH_DIV);
    localparam int              IW       = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]   PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic            INV      = (COMMON_ANODE != 0);

    logic [PW-1:0]           pre;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    pre_last;
    logic                    frame_end;
    logic [3:0]              cur_nibble;
    logic [6:0]              hex_seg;
    logic                    lz_zero;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [NUM_DIGITS-1:0]   sel_next;

    assign pre_last  = (pre == PRE_LAST);
    assign frame_end = pre_last && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre_last ? '0 : pre + 1'b1;
            if (pre_last) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Display only changes at the frame boundary so a frame never mixes two values
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            disp_value <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
            end
            if (frame_end) begin
                disp_value <= load ? value : pend_value;
                disp_dp    <= load ? dp_in : pend_dp;
            end
        end
    end

    assign cur_nibble = disp_value[{idx, 2'b00} +: 4];

    seven_segment_hex #(
        .HEX_MODE (HEX_MODE)
    ) u_hex (
        .nibble (cur_nibble),
        .seg    (hex_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero
    assign lz_zero    = lz_blank && (idx != '0) && ((disp_value >> {idx, 2'b00}) == '0);
    assign seg_next   = lz_zero ? SEG_BLANK : hex_seg;
    assign sel_onehot = NUM_DIGITS'(1) << idx;
    assign sel_next   = (32'(pre) < BLANK_CYCLES) ? '0 : sel_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= {7{INV}};
            dp         <= INV;
            digit_sel  <= {NUM_DIGITS{INV}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next ^ {7{INV}};
            dp         <= disp_dp[idx] ^ INV;
            digit_sel  <= sel_next ^ {NUM_DIGITS{INV}};
            frame_tick <= (pre == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = N * DIV;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] value    = '0;
    logic [3:0]  dp_in    = '0;
    logic        lz_blank = 1'b0;
    logic        load     = 1'b0;

    logic [6:0] seg_h, seg_d, seg_c;
    logic       dp_h, dp_d, dp_c;
    logic [3:0] sel_h, sel_d, sel_c;
    logic       tick_h, tick_d, tick_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                         .HEX_MODE(1), .COMMON_ANODE(0)) u_hexm (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank), .load(load),
        .seg(seg_h), .dp(dp_h), .digit_sel(sel_h), .frame_tick(tick_h));

    seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                         .HEX_MODE(0), .COMMON_ANODE(0)) u_decm (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank), .load(load),
        .seg(seg_d), .dp(dp_d), .digit_sel(sel_d), .frame_tick(tick_d));

    seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                         .HEX_MODE(1), .COMMON_ANODE(1)) u_ca (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank), .load(load),
        .seg(seg_c), .dp(dp_c), .digit_sel(sel_c), .frame_tick(tick_c));

    // Reference model: time since reset decides slot and position; frames swap in the last load
    logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
                                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    int          t      = 0;
    int          m_pos;
    int          m_slot;
    int          m_top;
    logic [15:0] m_pend = '0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_pdp  = '0;
    logic [3:0]  m_ddp  = '0;
    logic [3:0]  m_nib;
    logic        m_blank;
    logic [6:0]  e_seg   = '0;
    logic [6:0]  e_seg_d = '0;
    logic        e_dp    = 1'b0;
    logic [3:0]  e_sel   = '0;
    logic        e_tick  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
            e_seg = '0; e_seg_d = '0; e_dp = 1'b0; e_sel = '0; e_tick = 1'b0;
        end else begin
            m_pos  = t % DIV;
            m_slot = (t / DIV) % N;
            m_top  = 0;
            for (int k = 0; k < N; k++) begin
                if (m_disp[4*k +: 4] != 4'h0) m_top = k;
            end
            m_nib   = m_disp[4*m_slot +: 4];
            m_blank = lz_blank && (m_slot > m_top);
            e_seg   = m_blank ? 7'b0 : seg_tab[m_nib];
            e_seg_d = (m_blank || m_nib > 4'd9) ? 7'b0 : seg_tab[m_nib];
            e_dp    = m_ddp[m_slot];
            e_sel   = (m_pos < BLANK) ? 4'b0000 : 4'(1 << m_slot);
            e_tick  = (m_pos == 0) && (m_slot == 0);
            if (load) begin
                m_pend = value;
                m_pdp  = dp_in;
            end
            if (t % FRAME == FRAME - 1) begin
                m_disp = m_pend;
                m_ddp  = m_pdp;
            end
            t++;
        end
    end

    logic [38:0] got_all, exp_all;
    assign got_all = {seg_h, dp_h, sel_h, tick_h, seg_d, dp_d, sel_d, tick_d, seg_c, dp_c, sel_c, tick_c};
    assign exp_all = {e_seg, e_dp, e_sel, e_tick, e_seg_d, e_dp, e_sel, e_tick,
                      ~e_seg, ~e_dp, ~e_sel, e_tick};

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!e_tick && k < 64);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seg_h, dp_h, sel_h, tick_h} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_ca0 got %b required %b", {seg_h, dp_h, sel_h, tick_h}, 13'b0);
        end
        n_checks++;
        if ({seg_c, dp_c, sel_c, tick_c} !== {7'h7f, 1'b1, 4'hf, 1'b0}) begin
            n_err++;
            $display("FAIL reset_ca1 got %b required %b", {seg_c, dp_c, sel_c, tick_c}, {7'h7f, 1'b1, 4'hf, 1'b0});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sel_h !== 4'b0000 || tick_h !== 1'b1) begin
            n_err++;
            $display("FAIL first_blank got sel=%b tick=%b required sel=0000 tick=1", sel_h, tick_h);
        end
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            if (j == 1) begin
                n_checks++;
                if (sel_h !== 4'b0001 || seg_h !== 7'b0111111 || sel_c !== 4'b1110 || seg_c !== 7'b1000000) begin
                    n_err++;
                    $display("FAIL first_digit got sel=%b seg=%b sel_ca=%b seg_ca=%b required 0001 0111111 1110 1000000",
                             sel_h, seg_h, sel_c, seg_c);
                end
            end
            n_checks++;
            if (tick_h !== (j == FRAME)) begin
                n_err++;
                $display("FAIL tick_period j=%0d got %b required %b", j, tick_h, (j == FRAME));
            end
            n_checks++;
            if (got_all !== exp_all) begin
                n_err++;
                $display("FAIL reset_model t=%0d got %h required %h", t, got_all, exp_all);
            end
        end
    endtask

    task automatic test_scan_order();
        logic [6:0] want [4];
        want = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
        do_load(16'h1234, 4'b0100);
        wait_frame();
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if (seg_h !== want[j/DIV] || sel_h !== ((j % DIV == 0) ? 4'b0000 : 4'(1 << (j/DIV)))
                || dp_h !== ((j/DIV) == 2)) begin
                n_err++;
                $display("FAIL scan_order j=%0d got seg=%b sel=%b dp=%b required seg=%b", j, seg_h, sel_h, dp_h, want[j/DIV]);
            end
            n_checks++;
            if (got_all !== exp_all) begin
                n_err++;
                $display("FAIL scan_model t=%0d got %h required %h", t, got_all, exp_all);
            end
        end
    endtask

    task automatic test_hex_mode();
        do_load(16'hABCD, 4'b0000);
        wait_frame();
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if (seg_d !== 7'b0 || (j < DIV && seg_h !== 7'b1011110)) begin
                n_err++;
                $display("FAIL hex_mode j=%0d got hex=%b dec=%b required hex=1011110 dec=0000000", j, seg_h, seg_d);
            end
            n_checks++;
            if (got_all !== exp_all) begin
                n_err++;
                $display("FAIL hex_model t=%0d got %h required %h", t, got_all, exp_all);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] want [4];
        lz_blank = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                want = '{7'b0111111, 7'b1101101, 7'b0, 7'b0};
                do_load(16'h0050, 4'b0000);
            end else begin
                want = '{7'b0111111, 7'b0, 7'b0, 7'b0};
                do_load(16'h0000, 4'b0000);
            end
            wait_frame();
            for (int j = 0; j < FRAME; j++) begin
                if (j > 0) @(negedge clk);
                n_checks++;
                if (seg_h !== want[j/DIV]) begin
                    n_err++;
                    $display("FAIL lz_blank pass=%0d j=%0d got %b required %b", pass, j, seg_h, want[j/DIV]);
                end
                n_checks++;
                if (got_all !== exp_all) begin
                    n_err++;
                    $display("FAIL lz_model t=%0d got %h required %h", t, got_all, exp_all);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_tear_free();
        int k;
        wait_frame();
        repeat (5) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        k = 0;
        while (!e_tick && k < 40) begin
            n_checks++;
            if (seg_h !== 7'b0111111) begin
                n_err++;
                $display("FAIL tear_hold got %b required 0111111", seg_h);
            end
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (tick_h !== 1'b1 || seg_h !== 7'b0000110) begin
            n_err++;
            $display("FAIL tear_swap got tick=%b seg=%b required tick=1 seg=0000110", tick_h, seg_h);
        end
        k = 0;
        while (t % FRAME != FRAME - 1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        do_load(16'h2222, 4'b0001);
        @(negedge clk);
        n_checks++;
        if (tick_h !== 1'b1 || seg_h !== 7'b1011011 || sel_h !== 4'b0000 || dp_h !== 1'b1) begin
            n_err++;
            $display("FAIL boundary_load got tick=%b seg=%b sel=%b dp=%b required 1 1011011 0000 1", tick_h, seg_h, sel_h, dp_h);
        end
        repeat (6) @(negedge clk);
        do_load(16'h9999, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({seg_h, dp_h, sel_h, tick_h} !== 13'b0 || {seg_c, dp_c, sel_c} !== 12'hfff) begin
            n_err++;
            $display("FAIL mid_reset got %b / %b required all inactive", {seg_h, dp_h, sel_h, tick_h}, {seg_c, dp_c, sel_c});
        end
        rst = 1'b0;
        for (int j = 0; j < 2 * FRAME; j++) begin
            @(negedge clk);
            n_checks++;
            if (seg_h !== 7'b0111111 || dp_h !== 1'b0 || tick_h !== (j % FRAME == 0)) begin
                n_err++;
                $display("FAIL reset_discard j=%0d got seg=%b dp=%b tick=%b required 0111111 0 %b", j, seg_h, dp_h, tick_h, (j % FRAME == 0));
            end
            n_checks++;
            if (got_all !== exp_all) begin
                n_err++;
                $display("FAIL tear_model t=%0d got %h required %h", t, got_all, exp_all);
            end
        end
    endtask

    task automatic test_polarity();
        do_load(16'h8888, 4'b0000);
        wait_frame();
        @(negedge clk);
        n_checks++;
        if (seg_c !== 7'b0000000 || sel_c !== 4'b1110 || dp_c !== 1'b1 || seg_h !== 7'b1111111 || sel_h !== 4'b0001) begin
            n_err++;
            $display("FAIL polarity got seg_ca=%b sel_ca=%b dp_ca=%b seg=%b sel=%b required 0000000 1110 1 1111111 0001",
                     seg_c, sel_c, dp_c, seg_h, sel_h);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++;
            if (got_all !== exp_all) begin
                n_err++;
                $display("FAIL random_model c=%0d t=%0d got %h required %h", c, t, got_all, exp_all);
            end
            for (int k = 0; k < N; k++) begin
                v[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
            value = v;
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
        end
        load = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_hex_mode();
        test_lz_blank();
        test_tear_free();
        test_polarity();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised, time-multiplexed driver for an N-digit seven-segment display. It succeeds the single-digit decoder. It latches a packed BCD/hex value, scans one digit at a time with a programmable refresh rate, and adds hex mode, per-digit decimal points, leading-zero blanking, tear-free frame updates, anti-ghost blanking and output polarity selection. It sits between the user datapath and the chip output pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 1000, clock cycles each digit stays selected (≥2)
- BLANK_CYCLES, 1, cycles at the start of each digit slot with all digit selects inactive (0..REFRESH_DIV-1)
- HEX_MODE, 1, 1: nibbles 10..15 show A,b,C,d,E,F; 0: nibbles 10..15 show blank
- COMMON_ANODE, 0, 1: seg, dp and digit_sel are active-low; 0: active-high

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  packed nibbles; nibble 0 (bits 3:0) is the rightmost digit
- dp_in  in  NUM_DIGITS  decimal point per digit
- lz_blank  in  1  leading-zero blanking enable
- load  in  1  single-cycle strobe; captures value/dp_in
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal-point segment
- digit_sel  out  NUM_DIGITS  one-hot digit enable
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Pending register: captures value and dp_in on load.
- Display register: copied from pending at the frame boundary (prescaler terminal while the index is NUM_DIGITS-1). If load coincides with the boundary, display takes the new value/dp_in directly.
- Prescaler counts 0..REFRESH_DIV-1. At terminal it wraps to 0 and the digit index increments, wrapping NUM_DIGITS-1 → 0.
- Encoding (active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Non-decoded nibbles give 0000000.
- Leading-zero blanking (lz_blank=1): every zero nibble above the highest nonzero nibble shows seg=0000000. Digit 0 is never blanked. dp is unaffected by this blanking. lz_blank is sampled live, not latched.
- Anti-ghost: while prescaler < BLANK_CYCLES, digit_sel is all inactive. seg/dp still show the current digit.
- Polarity: when COMMON_ANODE=1, seg, dp and digit_sel are inverted at the output register.

## Timing
- seg, dp, digit_sel and frame_tick are registered. Each is a function of the index, prescaler and display register from the previous cycle (1-cycle latency).
- Reset values: prescaler 0, index 0, pending/display 0, frame_tick 0. seg, dp and digit_sel are at their inactive level (all 0, or all 1 if COMMON_ANODE).
- The first active digit_sel after reset is digit 0 at cycle BLANK_CYCLES+1.
- load → value visible on outputs: at the next frame boundary + 1 cycle. Worst case NUM_DIGITS*REFRESH_DIV+1 cycles.
- frame_tick is high for exactly the one output cycle in which index 0 becomes current. It occurs once per NUM_DIGITS*REFRESH_DIV cycles.
- rst mid-scan returns everything to reset state on the next edge. A pending load is discarded.
- Multiple loads within one frame: the last one wins.

## Structure
- Package seven_segment_pkg:
  - SEG_* encoding constants for 0..F and SEG_BLANK
  - function that maps a nibble plus hex_mode to 7 bits
- Sub-module seven_segment_hex: purely combinational nibble→segment decoder. It is instantiated once, on the muxed digit.
- Top-level contents: prescaler, index counter, pending/display registers, leading-zero mask, output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, COMMON_ANODE=0 unless stated.
- **Reset:** hold rst 3 cycles, release → seg=0, digit_sel=0000 for 1 cycle. Then digit_sel=0001 with seg=0111111; frame_tick high on the first index-0 cycle only.
- **Scan order:** load value=16'h1234, dp_in=4'b0100 → after the next boundary, digit slots in turn show:
  - digit 0 (digit_sel=0001): seg=1100110
  - digit 1 (0010): seg=1001111
  - digit 2 (0100): seg=1011011, dp=1
  - digit 3 (1000): seg=0000110
  - each slot lasts 4 cycles, with digit_sel=0000 in its first cycle.
- **Hex/decimal mode:** value=16'hABCD. HEX_MODE=1 → digit 0 shows 1011110 (d). HEX_MODE=0 → all digits show 0000000.
- **Leading-zero blanking:** value=16'h0050, lz_blank=1 → digits 3 and 2 show 0000000, digit 1 shows 1101101, digit 0 shows 0111111. value=16'h0000 → only digit 0 is lit.
- **Tear-free update:**
  - load 16'h1111 mid-frame → digits remain the old value until the frame boundary.
  - load coinciding with the boundary → the new value appears at index 0 of the next frame.
  - rst asserted mid-frame → outputs return to reset state next cycle.
- **Polarity:** COMMON_ANODE=1 → reset outputs are seg=1111111, dp=1, digit_sel=1111. Digit 0 showing 8 gives seg=0000000, digit_sel=1110.
